// File: rtl/mem_port_initiator.sv
// mem_port_initiator: requester side of the data memory port.
// Turns a valid/ready load/store request channel into MMU data-port accesses
// and returns exactly one response per accepted request, with an error code.
// One access outstanding at a time; MMU wait is bounded by WAIT_LIMIT cycles.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   req_valid/req_ready          request handshake
//   req_write/req_addr/req_wdata request payload (1=store, word address, store data)
//   rsp_valid/rsp_ready          response handshake
//   rsp_rdata/rsp_err            load data, error (00 ok, 01 segv, 10 timeout)
//   mem_addr/mem_wdata/mem_rd/mem_wd   MMU data-port request
//   mem_data/mem_wait/mem_segv   MMU data-port response
//   fault_count                  saturating count of segv and timeout responses
module mem_port_initiator #(
  parameter int unsigned WAIT_LIMIT  = 16,
  parameter int unsigned FAULT_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [31:0]            req_addr,
  input  logic [31:0]            req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [31:0]            rsp_rdata,
  output logic [1:0]             rsp_err,
  output logic [31:0]            mem_addr,
  output logic [31:0]            mem_wdata,
  output logic                   mem_rd,
  output logic                   mem_wd,
  input  logic [31:0]            mem_data,
  input  logic                   mem_wait,
  input  logic                   mem_segv,
  output logic [FAULT_CNT_W-1:0] fault_count
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned WCNT_W = 8;
  localparam int unsigned ERR_W  = 2;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

  localparam logic [ERR_W-1:0] ERR_OK      = 2'b00;
  localparam logic [ERR_W-1:0] ERR_SEGV    = 2'b01;
  localparam logic [ERR_W-1:0] ERR_TIMEOUT = 2'b10;

  // Counter value on the last wait cycle tolerated before timing out.
  localparam logic [WCNT_W-1:0]      WAIT_LAST = WCNT_W'(WAIT_LIMIT - 1);
  localparam logic [FAULT_CNT_W-1:0] FAULT_MAX = '1;

  logic [1:0]             state, state_nxt;
  logic                   is_write, is_write_nxt;
  logic [WCNT_W-1:0]      wait_cnt, wait_cnt_nxt;
  logic                   req_ready_nxt;
  logic                   rsp_valid_nxt;
  logic [DATA_W-1:0]      rsp_rdata_nxt;
  logic [ERR_W-1:0]       rsp_err_nxt;
  logic [ADDR_W-1:0]      mem_addr_nxt;
  logic [DATA_W-1:0]      mem_wdata_nxt;
  logic                   mem_rd_nxt;
  logic                   mem_wd_nxt;
  logic [FAULT_CNT_W-1:0] fault_count_nxt;

  // State and registered outputs; async reset drops mem_rd/mem_wd at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      is_write    <= 1'b0;
      wait_cnt    <= '0;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= ERR_OK;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_rd      <= 1'b0;
      mem_wd      <= 1'b0;
      fault_count <= '0;
    end else begin
      state       <= state_nxt;
      is_write    <= is_write_nxt;
      wait_cnt    <= wait_cnt_nxt;
      req_ready   <= req_ready_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_rdata   <= rsp_rdata_nxt;
      rsp_err     <= rsp_err_nxt;
      mem_addr    <= mem_addr_nxt;
      mem_wdata   <= mem_wdata_nxt;
      mem_rd      <= mem_rd_nxt;
      mem_wd      <= mem_wd_nxt;
      fault_count <= fault_count_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt       = state;
    is_write_nxt    = is_write;
    wait_cnt_nxt    = wait_cnt;
    rsp_valid_nxt   = rsp_valid;
    rsp_rdata_nxt   = rsp_rdata;
    rsp_err_nxt     = rsp_err;
    mem_addr_nxt    = mem_addr;
    mem_wdata_nxt   = mem_wdata;
    fault_count_nxt = fault_count;

    case (state)
      S_IDLE: begin
        wait_cnt_nxt = '0;
        if (req_valid) begin
          is_write_nxt  = req_write;
          mem_addr_nxt  = req_addr;
          mem_wdata_nxt = req_wdata;
          state_nxt     = S_REQ;
        end
      end
      S_REQ: begin
        // segv outranks wait: a faulting address never completes.
        if (mem_segv) begin
          rsp_err_nxt   = ERR_SEGV;
          rsp_rdata_nxt = '0;
          rsp_valid_nxt = 1'b1;
          state_nxt     = S_RESP;
        end else if (mem_wait && (wait_cnt == WAIT_LAST)) begin
          rsp_err_nxt   = ERR_TIMEOUT;
          rsp_rdata_nxt = '0;
          rsp_valid_nxt = 1'b1;
          state_nxt     = S_RESP;
        end else if (mem_wait) begin
          wait_cnt_nxt = wait_cnt + WCNT_W'(1);
        end else begin
          state_nxt = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        // MMU read data is registered, so it is valid the cycle after REQ.
        rsp_rdata_nxt = is_write ? '0 : mem_data;
        rsp_err_nxt   = ERR_OK;
        rsp_valid_nxt = 1'b1;
        state_nxt     = S_RESP;
      end
      S_RESP: begin
        if (rsp_valid && rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = S_IDLE;
        end
      end
    endcase

    // REQ goes straight to RESP only with an error.
    if ((state == S_REQ) && (state_nxt == S_RESP) && (fault_count != FAULT_MAX)) begin
      fault_count_nxt = fault_count + FAULT_CNT_W'(1);
    end

    req_ready_nxt = (state_nxt == S_IDLE);
    mem_rd_nxt    = (state_nxt == S_REQ) && !is_write_nxt;
    mem_wd_nxt    = (state_nxt == S_REQ) && is_write_nxt;
  end

endmodule
